alu_rs: RTL and testbench

//  ALU reservation station: the issuing side of the ALU calc interface. Buffers dispatched
//  ALU/branch ops, wakes operands from ALU and LSB broadcasts, and issues one operand-ready

---
 rtl/alu_rs_if.sv | 45 ++++
 rtl/alu_rs.sv | 169 ++++++++++++++++
 tb/tb_alu_rs.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Bundle between the ALU reservation station and its neighbours: dispatch input,
// ALU/LSB result broadcasts, and the issue channel to the ALU.
interface alu_rs_if #(
  parameter int ROB_WIDTH = 4
);
  logic                 disp_valid;
  logic [4:0]           disp_op;
  logic [31:0]          disp_vj;
  logic [31:0]          disp_vk;
  logic [ROB_WIDTH-1:0] disp_qj;
  logic [ROB_WIDTH-1:0] disp_qk;
  logic                 disp_qj_busy;
  logic                 disp_qk_busy;
  logic [ROB_WIDTH-1:0] disp_rob;
  logic [31:0]          disp_tja;
  logic [31:0]          disp_fja;
  logic                 full;
  logic                 alu_ready;
  logic [31:0]          alu_value;
  logic                 lsb_ready;
  logic [31:0]          lsb_value;
  logic [ROB_WIDTH-1:0] lsb_rob;
  logic                 calc_enable;
  logic [31:0]          lhs;
  logic [31:0]          rhs;
  logic [4:0]           op;
  logic [ROB_WIDTH-1:0] rob_dep;
  logic [31:0]          true_jaddr;
  logic [31:0]          false_jaddr;
  logic [ROB_WIDTH-1:0] res_rob;

  modport master (
    output disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_busy, disp_qk_busy, disp_rob, disp_tja, disp_fja,
           alu_ready, alu_value, lsb_ready, lsb_value, lsb_rob,
    input  full, calc_enable, lhs, rhs, op, rob_dep, true_jaddr, false_jaddr, res_rob
  );

  modport slave (
    input  disp_valid, disp_op, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_busy, disp_qk_busy, disp_rob, disp_tja, disp_fja,
           alu_ready, alu_value, lsb_ready, lsb_value, lsb_rob,
    output full, calc_enable, lhs, rhs, op, rob_dep, true_jaddr, false_jaddr, res_rob
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ops, wakes operands from ALU/LSB
// broadcasts and issues one ready entry per cycle to the ALU.
module alu_rs #(
  parameter int RS_WIDTH  = 3,
  parameter int ROB_WIDTH = 4
) (
  input  logic   clk_in,
  input  logic   rst_in,
  input  logic   rdy_in,
  input  logic   clear,
  alu_rs_if.slave bus
);
  localparam int RS_SIZE = 1 << RS_WIDTH;

  logic [RS_SIZE-1:0]   r_busy;
  logic [RS_SIZE-1:0]   r_qjBusy;
  logic [RS_SIZE-1:0]   r_qkBusy;
  logic [4:0]           r_op  [RS_SIZE];
  logic [31:0]          r_vj  [RS_SIZE];
  logic [31:0]          r_vk  [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qj  [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_qk  [RS_SIZE];
  logic [ROB_WIDTH-1:0] r_rob [RS_SIZE];
  logic [31:0]          r_tja [RS_SIZE];
  logic [31:0]          r_fja [RS_SIZE];

  logic                 r_calcEnable;
  logic [31:0]          r_lhs;
  logic [31:0]          r_rhs;
  logic [4:0]           r_issueOp;
  logic [ROB_WIDTH-1:0] r_robDep;
  logic [31:0]          r_trueJaddr;
  logic [31:0]          r_falseJaddr;
  logic [ROB_WIDTH-1:0] r_resRob;

  logic                 w_full;
  logic                 w_freeFound;
  logic [RS_WIDTH-1:0]  w_freeIdx;
  logic                 w_selFound;
  logic [RS_WIDTH-1:0]  w_selIdx;
  logic [32:0]          w_jWake [RS_SIZE];
  logic [32:0]          w_kWake [RS_SIZE];
  logic [32:0]          w_djWake;
  logic [32:0]          w_dkWake;

  // Returns {hit, value}; the ALU broadcast is tagged by the in-flight tag r_resRob.
  function automatic logic [32:0] lookup(
    input logic [ROB_WIDTH-1:0] tag,
    input logic                 aluRdy,
    input logic [ROB_WIDTH-1:0] aluTag,
    input logic [31:0]          aluVal,
    input logic                 lsbRdy,
    input logic [ROB_WIDTH-1:0] lsbTag,
    input logic [31:0]          lsbVal
  );
    if (aluRdy && tag == aluTag)      lookup = {1'b1, aluVal};
    else if (lsbRdy && tag == lsbTag) lookup = {1'b1, lsbVal};
    else                              lookup = {1'b0, 32'd0};
  endfunction

  assign w_full = &r_busy;

  always_comb begin
    w_freeFound = 1'b0;
    w_freeIdx   = '0;
    w_selFound  = 1'b0;
    w_selIdx    = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_freeFound = 1'b1;
        w_freeIdx   = RS_WIDTH'(i);
      end
      if (r_busy[i] && !r_qjBusy[i] && !r_qkBusy[i]) begin
        w_selFound = 1'b1;
        w_selIdx   = RS_WIDTH'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      w_jWake[i] = lookup(r_qj[i], bus.alu_ready, r_resRob, bus.alu_value,
                          bus.lsb_ready, bus.lsb_rob, bus.lsb_value);
      w_kWake[i] = lookup(r_qk[i], bus.alu_ready, r_resRob, bus.alu_value,
                          bus.lsb_ready, bus.lsb_rob, bus.lsb_value);
    end
    w_djWake = lookup(bus.disp_qj, bus.alu_ready, r_resRob, bus.alu_value,
                      bus.lsb_ready, bus.lsb_rob, bus.lsb_value);
    w_dkWake = lookup(bus.disp_qk, bus.alu_ready, r_resRob, bus.alu_value,
                      bus.lsb_ready, bus.lsb_rob, bus.lsb_value);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_busy       <= '0;
      r_qjBusy     <= '0;
      r_qkBusy     <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_op[i]  <= '0;
        r_vj[i]  <= '0;
        r_vk[i]  <= '0;
        r_qj[i]  <= '0;
        r_qk[i]  <= '0;
        r_rob[i] <= '0;
        r_tja[i] <= '0;
        r_fja[i] <= '0;
      end
      r_calcEnable <= 1'b0;
      r_lhs        <= '0;
      r_rhs        <= '0;
      r_issueOp    <= '0;
      r_robDep     <= '0;
      r_trueJaddr  <= '0;
      r_falseJaddr <= '0;
      r_resRob     <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        r_busy       <= '0;
        r_calcEnable <= 1'b0;
      end else begin
        r_calcEnable <= w_selFound;
        if (r_calcEnable) r_resRob <= r_robDep;
        for (int i = 0; i < RS_SIZE; i++) begin
          if (r_busy[i] && r_qjBusy[i] && w_jWake[i][32]) begin
            r_vj[i]     <= w_jWake[i][31:0];
            r_qjBusy[i] <= 1'b0;
          end
          if (r_busy[i] && r_qkBusy[i] && w_kWake[i][32]) begin
            r_vk[i]     <= w_kWake[i][31:0];
            r_qkBusy[i] <= 1'b0;
          end
        end
        if (w_selFound) begin
          r_lhs            <= r_vj[w_selIdx];
          r_rhs            <= r_vk[w_selIdx];
          r_issueOp        <= r_op[w_selIdx];
          r_robDep         <= r_rob[w_selIdx];
          r_trueJaddr      <= r_tja[w_selIdx];
          r_falseJaddr     <= r_fja[w_selIdx];
          r_busy[w_selIdx] <= 1'b0;
        end
        // Full is judged on registered occupancy, so a slot freed by this issue is not reused yet.
        if (bus.disp_valid && !w_full && w_freeFound) begin
          r_busy[w_freeIdx]   <= 1'b1;
          r_op[w_freeIdx]     <= bus.disp_op;
          r_qj[w_freeIdx]     <= bus.disp_qj;
          r_qk[w_freeIdx]     <= bus.disp_qk;
          r_rob[w_freeIdx]    <= bus.disp_rob;
          r_tja[w_freeIdx]    <= bus.disp_tja;
          r_fja[w_freeIdx]    <= bus.disp_fja;
          r_qjBusy[w_freeIdx] <= bus.disp_qj_busy && !w_djWake[32];
          r_qkBusy[w_freeIdx] <= bus.disp_qk_busy && !w_dkWake[32];
          r_vj[w_freeIdx]     <= (bus.disp_qj_busy && w_djWake[32]) ? w_djWake[31:0] : bus.disp_vj;
          r_vk[w_freeIdx]     <= (bus.disp_qk_busy && w_dkWake[32]) ? w_dkWake[31:0] : bus.disp_vk;
        end
      end
    end
  end

  assign bus.full        = w_full;
  assign bus.calc_enable = r_calcEnable;
  assign bus.lhs         = r_lhs;
  assign bus.rhs         = r_rhs;
  assign bus.op          = r_issueOp;
  assign bus.rob_dep     = r_robDep;
  assign bus.true_jaddr  = r_trueJaddr;
  assign bus.false_jaddr = r_falseJaddr;
  assign bus.res_rob     = r_resRob;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue latency, wakeup/bypass, full handling,
// select priority, clear, pause and asynchronous reset.
module tb_alu_rs;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rdy   = 1'b1;
  logic clr   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_rs_if #(.ROB_WIDTH(4)) bus ();

  alu_rs #(.RS_WIDTH(3), .ROB_WIDTH(4)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .rdy_in (rdy),
    .clear  (clr),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    bus.disp_valid   = 1'b0;
    bus.disp_op      = '0;
    bus.disp_vj      = '0;
    bus.disp_vk      = '0;
    bus.disp_qj      = '0;
    bus.disp_qk      = '0;
    bus.disp_qj_busy = 1'b0;
    bus.disp_qk_busy = 1'b0;
    bus.disp_rob     = '0;
    bus.disp_tja     = '0;
    bus.disp_fja     = '0;
    bus.alu_ready    = 1'b0;
    bus.alu_value    = '0;
    bus.lsb_ready    = 1'b0;
    bus.lsb_value    = '0;
    bus.lsb_rob      = '0;
  endtask

  // Branch targets are derived from the tag so every issue carries distinct addresses.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] vj, input logic [31:0] vk,
                               input logic [3:0] qj, input logic qjBusy,
                               input logic [3:0] qk, input logic qkBusy, input logic [3:0] rob);
    bus.disp_valid   = 1'b1;
    bus.disp_op      = op;
    bus.disp_vj      = vj;
    bus.disp_vk      = vk;
    bus.disp_qj      = qj;
    bus.disp_qk      = qk;
    bus.disp_qj_busy = qjBusy;
    bus.disp_qk_busy = qkBusy;
    bus.disp_rob     = rob;
    bus.disp_tja     = 32'h100 + 32'(rob);
    bus.disp_fja     = 32'h200 + 32'(rob);
  endtask

  task automatic checkIssue(input string tag, input logic [31:0] lhs, input logic [31:0] rhs,
                            input logic [3:0] rob);
    checkOutput({tag, " calc_enable"}, 32'(bus.calc_enable), 32'd1);
    checkOutput({tag, " lhs"}, bus.lhs, lhs);
    checkOutput({tag, " rhs"}, bus.rhs, rhs);
    checkOutput({tag, " rob_dep"}, 32'(bus.rob_dep), 32'(rob));
  endtask

  initial begin
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset calc_enable", 32'(bus.calc_enable), 32'd0);
    checkOutput("reset full", 32'(bus.full), 32'd0);
    checkOutput("reset res_rob", 32'(bus.res_rob), 32'd0);
    checkOutput("reset lhs", bus.lhs, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Ready ADD: one cycle to land in an entry, issued on the next edge.
    applyStimulus(5'd0, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
    tick();
    idleInputs();
    checkOutput("add not yet issued", 32'(bus.calc_enable), 32'd0);
    tick();
    checkIssue("add issue", 32'd5, 32'd7, 4'd3);
    checkOutput("add op", 32'(bus.op), 32'd0);
    checkOutput("add true_jaddr", bus.true_jaddr, 32'h103);
    checkOutput("add false_jaddr", bus.false_jaddr, 32'h203);
    tick();
    checkOutput("add pulse ends", 32'(bus.calc_enable), 32'd0);
    checkOutput("add res_rob", 32'(bus.res_rob), 32'd3);
    checkOutput("add payload holds", bus.lhs, 32'd5);

    // LSB wakeup after dispatch.
    applyStimulus(5'd1, 32'd0, 32'd1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4);
    tick();
    idleInputs();
    tick();
    checkOutput("wait for lsb", 32'(bus.calc_enable), 32'd0);
    bus.lsb_ready = 1'b1;
    bus.lsb_rob   = 4'd2;
    bus.lsb_value = 32'h10;
    tick();
    idleInputs();
    checkOutput("wake edge no issue", 32'(bus.calc_enable), 32'd0);
    tick();
    checkIssue("lsb wake issue", 32'h10, 32'd1, 4'd4);
    checkOutput("lsb wake op", 32'(bus.op), 32'd1);
    tick();

    // Bypass: broadcast arrives in the dispatch cycle.
    applyStimulus(5'd0, 32'hdead, 32'd2, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5);
    bus.lsb_ready = 1'b1;
    bus.lsb_rob   = 4'd2;
    bus.lsb_value = 32'h20;
    tick();
    idleInputs();
    tick();
    checkIssue("bypass issue", 32'h20, 32'd2, 4'd5);
    tick();
    checkOutput("bypass res_rob", 32'(bus.res_rob), 32'd5);

    // Fill all 8 entries; entry 6 depends on tag 5 (entry 5's result), others on 8+i.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(5'd2, 32'd0, 32'(i), (i == 6) ? 4'd5 : 4'(i + 8), 1'b1, 4'd0, 1'b0, 4'(i));
      tick();
      if (i == 6) checkOutput("seven busy not full", 32'(bus.full), 32'd0);
    end
    idleInputs();
    checkOutput("eight busy full", 32'(bus.full), 32'd1);
    applyStimulus(5'd0, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15);
    tick();
    idleInputs();
    checkOutput("full after drop", 32'(bus.full), 32'd1);
    tick();
    checkOutput("dropped op no issue", 32'(bus.calc_enable), 32'd0);
    bus.lsb_ready = 1'b1;
    bus.lsb_rob   = 4'd13;
    bus.lsb_value = 32'h55;
    tick();
    idleInputs();
    checkOutput("woken entry still full", 32'(bus.full), 32'd1);
    tick();
    checkIssue("entry5 issue", 32'h55, 32'd5, 4'd5);
    checkOutput("full drops", 32'(bus.full), 32'd0);
    tick();
    checkOutput("entry5 res_rob", 32'(bus.res_rob), 32'd5);

    // Wake entry 1 (LSB tag 9) and entry 6 (ALU result of tag 5) together.
    bus.alu_ready = 1'b1;
    bus.alu_value = 32'h66;
    bus.lsb_ready = 1'b1;
    bus.lsb_rob   = 4'd9;
    bus.lsb_value = 32'h99;
    tick();
    idleInputs();
    checkOutput("dual wake edge", 32'(bus.calc_enable), 32'd0);
    tick();
    checkIssue("entry1 first", 32'h99, 32'd1, 4'd1);
    tick();
    checkIssue("entry6 second", 32'h66, 32'd6, 4'd6);
    checkOutput("entry1 res_rob", 32'(bus.res_rob), 32'd1);
    tick();
    checkOutput("dual idle", 32'(bus.calc_enable), 32'd0);
    checkOutput("entry6 res_rob", 32'(bus.res_rob), 32'd6);

    // Issue entry 7, leaving entries 0,2,3,4 busy.
    bus.lsb_ready = 1'b1;
    bus.lsb_rob   = 4'd15;
    bus.lsb_value = 32'h77;
    tick();
    idleInputs();
    tick();
    checkIssue("entry7 issue", 32'h77, 32'd7, 4'd7);
    tick();
    checkOutput("entry7 res_rob", 32'(bus.res_rob), 32'd7);
    bus.lsb_ready = 1'b1;
    bus.lsb_rob   = 4'd8;
    bus.lsb_value = 32'h88;
    tick();
    idleInputs();
    clr = 1'b1;
    applyStimulus(5'd0, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd12);
    tick();
    clr = 1'b0;
    idleInputs();
    checkOutput("clear calc_enable", 32'(bus.calc_enable), 32'd0);
    checkOutput("clear full", 32'(bus.full), 32'd0);
    checkOutput("clear res_rob holds", 32'(bus.res_rob), 32'd7);
    tick();
    checkOutput("cleared entry0 gone", 32'(bus.calc_enable), 32'd0);
    tick();
    checkOutput("clear dispatch dropped", 32'(bus.calc_enable), 32'd0);

    // Pause while an issue is on the outputs.
    applyStimulus(5'd3, 32'h11, 32'h22, 4'd0, 1'b0, 4'd0, 1'b0, 4'd10);
    tick();
    idleInputs();
    tick();
    checkIssue("pre pause issue", 32'h11, 32'h22, 4'd10);
    rdy = 1'b0;
    applyStimulus(5'd0, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd11);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("pause calc_enable", 32'(bus.calc_enable), 32'd1);
      checkOutput("pause rob_dep", 32'(bus.rob_dep), 32'd10);
      checkOutput("pause res_rob", 32'(bus.res_rob), 32'd7);
    end
    rdy = 1'b1;
    idleInputs();
    tick();
    checkOutput("resume calc_enable", 32'(bus.calc_enable), 32'd0);
    checkOutput("resume res_rob", 32'(bus.res_rob), 32'd10);
    tick();
    checkOutput("paused dispatch dropped", 32'(bus.calc_enable), 32'd0);

    // Asynchronous reset in the middle of an issue.
    applyStimulus(5'd0, 32'd3, 32'd4, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2);
    tick();
    idleInputs();
    tick();
    checkIssue("pre reset issue", 32'd3, 32'd4, 4'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset calc_enable", 32'(bus.calc_enable), 32'd0);
    checkOutput("async reset full", 32'(bus.full), 32'd0);
    checkOutput("async reset rob_dep", 32'(bus.rob_dep), 32'd0);
    checkOutput("async reset res_rob", 32'(bus.res_rob), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    applyStimulus(5'd0, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9);
    tick();
    idleInputs();
    tick();
    checkIssue("post reset issue", 32'd1, 32'd1, 4'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
